// File: rtl/commit_trace_pkg.sv
// Shared trace record format and constants for the commit trace capture path,
// imported by the capture buffer, the instruction tracer and the trace sink.
package commit_trace_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int TSTAMP_W   = 32;

    typedef struct packed {
        logic [63:0]         pc;
        logic [31:0]         instr;
        logic [4:0]          rd;
        logic                we;
        logic [63:0]         wdata;
        logic                ex;
        logic [1:0]          priv;
        logic                lost;
        logic [TSTAMP_W-1:0] tstamp;
    } trace_rec_t;

    // Adds up to 3 to the loss counter, sticking at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                      input logic [1:0]            b);
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, b};
        return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Generic FIFO accepting 0, 1 or 2 writes and at most one read per cycle.
// The caller must never enable more writes than free_o allows.
module trace_fifo_2w1r #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               wr_en_i,
    input  logic [W-1:0]             wr_data0_i,
    input  logic [W-1:0]             wr_data1_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   free_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [AW-1:0] wr_idx0;
    logic [AW-1:0] wr_idx_b;
    logic          pop;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign empty_o  = (count == '0);
    assign full_o   = (count == PW'(DEPTH));
    assign free_o   = PW'(DEPTH) - count;
    assign pop      = rd_en_i && !empty_o;
    assign wr_idx0  = wr_ptr[AW-1:0];
    assign wr_idx_b = wr_en_i[0] ? (wr_idx0 + AW'(1)) : wr_idx0;
    assign rd_data_o = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_en_i[0]) + PW'(wr_en_i[1]);
            rd_ptr <= rd_ptr + PW'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (wr_en_i[0]) mem[wr_idx0]  <= wr_data0_i;
        if (wr_en_i[1]) mem[wr_idx_b] <= wr_data1_i;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Packs up to two retired instructions per cycle into trace records and buffers them.
// Define COMMIT_TRACE_TSTAMP_EN to populate tstamp from a free-running cycle counter.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int NR_COMMIT_PORTS = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                enable_i,
    input  logic [NR_COMMIT_PORTS-1:0]          commit_ack_i,
    input  logic [NR_COMMIT_PORTS-1:0][63:0]    commit_pc_i,
    input  logic [NR_COMMIT_PORTS-1:0][31:0]    commit_instr_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]     commit_rd_i,
    input  logic [NR_COMMIT_PORTS-1:0]          commit_we_i,
    input  logic [NR_COMMIT_PORTS-1:0][63:0]    commit_wdata_i,
    input  logic [NR_COMMIT_PORTS-1:0]          commit_ex_i,
    input  logic [1:0]                          priv_lvl_i,
    output logic                                trace_valid_o,
    input  logic                                trace_ready_i,
    output trace_rec_t                          trace_rec_o,
    output logic [DROP_CNT_W-1:0]               drop_cnt_o,
    output logic                                full_o
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [NR_COMMIT_PORTS-1:0] commit_vld;
    trace_rec_t                 rec [NR_COMMIT_PORTS];
    trace_rec_t                 slot_a;
    trace_rec_t                 slot_b;
    trace_rec_t                 head;
    logic [1:0]                 n_commit;
    logic [1:0]                 n_write;
    logic [1:0]                 n_drop;
    logic [PW-1:0]              free;
    logic                       empty;
    logic                       lost_pending;
    logic [DROP_CNT_W-1:0]      drop_cnt_q;
    logic [TSTAMP_W-1:0]        tstamp;

`ifdef COMMIT_TRACE_TSTAMP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) tstamp <= '0;
        else       tstamp <= tstamp + TSTAMP_W'(1);
    end
`else
    assign tstamp = '0;
`endif

    assign commit_vld = enable_i ? commit_ack_i : '0;

    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            rec[p]        = '0;
            rec[p].pc     = commit_pc_i[p];
            rec[p].instr  = commit_instr_i[p];
            rec[p].rd     = commit_rd_i[p];
            rec[p].we     = commit_we_i[p];
            rec[p].wdata  = commit_wdata_i[p];
            rec[p].ex     = commit_ex_i[p];
            rec[p].priv   = priv_lvl_i;
            rec[p].tstamp = tstamp;
        end
        // Valid commits are compacted so the first one always lands in write slot A.
        slot_a      = commit_vld[0] ? rec[0] : rec[1];
        slot_a.lost = lost_pending;
        slot_b      = rec[1];
        n_commit    = {1'b0, commit_vld[0]} + {1'b0, commit_vld[1]};
        n_write     = (free >= PW'(n_commit)) ? n_commit : free[1:0];
        n_drop      = n_commit - n_write;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lost_pending <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            // A drop re-arms the flag even if this cycle's write consumed it.
            if (n_drop != 2'd0)       lost_pending <= 1'b1;
            else if (n_write != 2'd0) lost_pending <= 1'b0;
            drop_cnt_q <= sat_add(drop_cnt_q, n_drop);
        end
    end

    trace_fifo_2w1r #(
        .DEPTH (DEPTH),
        .W     ($bits(trace_rec_t))
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    ({n_write == 2'd2, n_write != 2'd0}),
        .wr_data0_i (slot_a),
        .wr_data1_i (slot_b),
        .rd_en_i    (trace_ready_i),
        .rd_data_o  (head),
        .empty_o    (empty),
        .full_o     (full_o),
        .free_o     (free)
    );

    assign trace_valid_o = !empty;
    assign trace_rec_o   = empty ? '0 : head;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_commit_trace_buffer;
    import commit_trace_pkg::*;

    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [1:0]       ack;
    logic [1:0][63:0] pc;
    logic [1:0][31:0] instr;
    logic [1:0][4:0]  rd;
    logic [1:0]       we;
    logic [1:0][63:0] wdata;
    logic [1:0]       ex;
    logic [1:0]       priv;
    logic             ready;
    logic             trace_valid;
    trace_rec_t       trace_rec;
    logic [15:0]      drop_cnt;
    logic             full;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .NR_COMMIT_PORTS(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .commit_ack_i   (ack),
        .commit_pc_i    (pc),
        .commit_instr_i (instr),
        .commit_rd_i    (rd),
        .commit_we_i    (we),
        .commit_wdata_i (wdata),
        .commit_ex_i    (ex),
        .priv_lvl_i     (priv),
        .trace_valid_o  (trace_valid),
        .trace_ready_i  (ready),
        .trace_rec_o    (trace_rec),
        .drop_cnt_o     (drop_cnt),
        .full_o         (full)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: list of buffered records, loss count, loss flag, cycle count.
    trace_rec_t  mq[$];
    int          m_drop;
    bit          m_lp;
    logic [31:0] m_ts;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic trace_rec_t mk(input int p);
        trace_rec_t r;
        r       = '0;
        r.pc    = pc[p];
        r.instr = instr[p];
        r.rd    = rd[p];
        r.we    = we[p];
        r.wdata = wdata[p];
        r.ex    = ex[p];
        r.priv  = priv;
`ifdef COMMIT_TRACE_TSTAMP_EN
        r.tstamp = m_ts;
`endif
        return r;
    endfunction

    // Advance one clock: update the model from the applied inputs, then compare outputs.
    task automatic step();
        trace_rec_t r;
        trace_rec_t exp_rec;
        int         room;
        bit         pop;
        if (rst) begin
            mq.delete();
            m_drop = 0;
            m_lp   = 1'b0;
            m_ts   = '0;
        end else begin
            pop  = (mq.size() != 0) && ready;
            room = DEPTH - mq.size();
            for (int p = 0; p < 2; p++) begin
                if (enable && ack[p]) begin
                    if (room > 0) begin
                        r      = mk(p);
                        r.lost = m_lp;
                        m_lp   = 1'b0;
                        mq.push_back(r);
                        room--;
                    end else begin
                        m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
                        m_lp   = 1'b1;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            m_ts = m_ts + 32'd1;
        end
        @(posedge clk);
        #1;
        exp_rec = '0;
        if (mq.size() != 0) exp_rec = mq[0];
        check("valid", trace_valid, mq.size() != 0);
        check("rec", trace_rec, exp_rec);
        check("full", full, mq.size() == DEPTH);
        check("drop", drop_cnt, m_drop);
    endtask

    typedef struct {
        bit          en;
        bit [1:0]    ack;
        bit          ready;
        logic [63:0] pc0;
        logic [63:0] pc1;
        bit          exp_valid;
        logic [63:0] exp_pc;
        bit          exp_full;
        int          exp_drop;
    } vec_t;

    function automatic vec_t mkv(bit e, bit [1:0] a, bit rdy, logic [63:0] p0, logic [63:0] p1,
                                 bit ev, logic [63:0] epc, bit ef, int ed);
        vec_t v;
        v.en = e; v.ack = a; v.ready = rdy; v.pc0 = p0; v.pc1 = p1;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_full = ef; v.exp_drop = ed;
        return v;
    endfunction

    vec_t        vecs [13];
    logic [63:0] drain_pc   [7];
    bit          drain_lost [7];

    initial begin
        vecs[0]  = mkv(1, 2'b01, 1, 64'h8000_0000, 64'h0,     1, 64'h8000_0000, 0, 0);
        vecs[1]  = mkv(0, 2'b11, 1, 64'hdead0,     64'hdead4, 0, 64'h0,         0, 0);
        vecs[2]  = mkv(1, 2'b11, 0, 64'h100,       64'h104,   1, 64'h100,       0, 0);
        vecs[3]  = mkv(0, 2'b11, 1, 64'hbeef0,     64'hbeef4, 1, 64'h104,       0, 0);
        vecs[4]  = mkv(1, 2'b00, 1, 64'h0,         64'h0,     0, 64'h0,         0, 0);
        vecs[5]  = mkv(1, 2'b11, 0, 64'h200,       64'h204,   1, 64'h200,       0, 0);
        vecs[6]  = mkv(1, 2'b11, 0, 64'h208,       64'h20c,   1, 64'h200,       0, 0);
        vecs[7]  = mkv(1, 2'b11, 0, 64'h210,       64'h214,   1, 64'h200,       0, 0);
        vecs[8]  = mkv(1, 2'b11, 0, 64'h218,       64'h21c,   1, 64'h200,       1, 0);
        vecs[9]  = mkv(1, 2'b11, 0, 64'h220,       64'h224,   1, 64'h200,       1, 2);
        vecs[10] = mkv(1, 2'b00, 1, 64'h0,         64'h0,     1, 64'h204,       0, 2);
        vecs[11] = mkv(1, 2'b11, 1, 64'h300,       64'h304,   1, 64'h208,       0, 3);
        vecs[12] = mkv(1, 2'b01, 1, 64'h310,       64'h0,     1, 64'h20c,       0, 3);
        drain_pc   = '{64'h20c, 64'h210, 64'h214, 64'h218, 64'h21c, 64'h300, 64'h310};
        drain_lost = '{0, 0, 0, 0, 0, 1, 1};

        rst = 1'b1; enable = 1'b0; ack = '0; ready = 1'b0;
        pc = '0; instr = '0; rd = '0; we = '0; wdata = '0; ex = '0; priv = 2'd3;
        step();
        step();
        rst = 1'b0;

        // Directed table.
        instr = {32'h00a00113, 32'h00500093};
        rd    = {5'd2, 5'd1};
        we    = 2'b11;
        wdata = {64'd10, 64'd5};
        for (int i = 0; i < 13; i++) begin
            enable = vecs[i].en;
            ack    = vecs[i].ack;
            ready  = vecs[i].ready;
            pc     = {vecs[i].pc1, vecs[i].pc0};
            step();
            check($sformatf("row%0d_valid", i), trace_valid, vecs[i].exp_valid);
            check($sformatf("row%0d_pc", i), trace_rec.pc, vecs[i].exp_pc);
            check($sformatf("row%0d_full", i), full, vecs[i].exp_full);
            check($sformatf("row%0d_drop", i), drop_cnt, vecs[i].exp_drop);
            if (i == 0) begin
                check("row0_instr", trace_rec.instr, 32'h00500093);
                check("row0_rd", trace_rec.rd, 5'd1);
                check("row0_wdata", trace_rec.wdata, 64'd5);
                check("row0_lost", trace_rec.lost, 1'b0);
            end
        end

        // Drain the survivors of the overflow; only the records written after losses are flagged.
        enable = 1'b1; ack = '0; ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("drain%0d_pc", i), trace_rec.pc, drain_pc[i]);
            check($sformatf("drain%0d_lost", i), trace_rec.lost, drain_lost[i]);
            step();
        end
        check("drained_valid", trace_valid, 1'b0);

        // Reset in the middle of buffered traffic.
        ready = 1'b0; ack = 2'b11; pc = {64'h504, 64'h500};
        step();
        pc = {64'h50c, 64'h508};
        step();
        rst = 1'b1; ack = '0;
        step();
        check("rst_valid", trace_valid, 1'b0);
        check("rst_drop", drop_cnt, 16'd0);
        rst = 1'b0; ack = 2'b01; pc = {64'h0, 64'h600};
        step();
        check("rst_tstamp", trace_rec.tstamp, 32'd0);
        check("rst_pc", trace_rec.pc, 64'h600);
        ack = '0; ready = 1'b1;
        step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 7) != 0);
            ack    = 2'($urandom);
            ready  = ($urandom_range(0, 2) != 0);
            pc     = {$urandom, $urandom, $urandom, $urandom};
            instr  = {$urandom, $urandom};
            rd     = 10'($urandom);
            we     = 2'($urandom);
            wdata  = {$urandom, $urandom, $urandom, $urandom};
            ex     = 2'($urandom);
            priv   = 2'($urandom);
            step();
        end
        rst = 1'b0;

        // Saturation of the loss counter.
        rst = 1'b1;
        step();
        rst = 1'b0; enable = 1'b1; ready = 1'b0; ack = 2'b11;
        repeat (4) step();
        repeat (32767) step();
        check("sat_fffe", drop_cnt, 16'hFFFE);
        step();
        check("sat_ffff", drop_cnt, 16'hFFFF);
        step();
        check("sat_hold", drop_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
